// File: rtl/cnn_fixed_pkg.sv
// Shared Q5.11 fixed-point constants and the MAC window FSM state encoding.
package cnn_fixed_pkg;

  localparam int CNN_DATA_W = 16;
  localparam int CNN_FRAC_W = 11;

  localparam logic [CNN_DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [CNN_DATA_W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_e;

endpackage

// File: rtl/conv_window_mac_if.sv
// Start/bias command, pixel/weight stream and result handshake of one MAC window engine.
interface conv_window_mac_if
  import cnn_fixed_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W
);

  logic              start;
  logic [DATA_W-1:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pixel;
  logic [DATA_W-1:0] weight;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sat_flag;
  logic              busy;

  modport master (
    output start, bias, in_valid, pixel, weight, out_ready,
    input  in_ready, out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  start, bias, in_valid, pixel, weight, out_ready,
    output in_ready, out_valid, out_data, sat_flag, busy
  );

endinterface

// File: rtl/conv_window_mac_sat.sv
// Accumulator to Q5.11 conversion: arithmetic floor shift, then clamp to the signed DATA_W range.
module q_acc_saturate
  import cnn_fixed_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int DATA_W = CNN_DATA_W,
  parameter int FRAC_W = CNN_FRAC_W
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic        [DATA_W-1:0] o_data,
  output logic                     o_sat
);

  logic signed [ACC_W-1:0]    w_r;
  logic        [ACC_W-DATA_W:0] w_hi;
  logic                       w_pos_ovf;
  logic                       w_neg_ovf;

  assign w_r  = i_acc >>> FRAC_W;
  // The value fits DATA_W exactly when every bit from DATA_W-1 upward equals the sign.
  assign w_hi = w_r[ACC_W-1:DATA_W-1];
  assign w_pos_ovf = ~w_hi[ACC_W-DATA_W] & (|w_hi);
  assign w_neg_ovf =  w_hi[ACC_W-DATA_W] & ~(&w_hi);

  always_comb begin
    o_data = w_r[DATA_W-1:0];
    o_sat  = 1'b0;
    if (w_pos_ovf) begin
      o_data = {1'b0, {(DATA_W-1){1'b1}}};
      o_sat  = 1'b1;
    end else if (w_neg_ovf) begin
      o_data = {1'b1, {(DATA_W-1){1'b0}}};
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Sequential multiply-accumulate over one convolution window with bias, one-stage product
// pipeline and a saturated Q5.11 result held until downstream accepts it.
//
//  state | meaning
//  IDLE  | waiting for start; bias is loaded into the accumulator on start
//  ACCUM | in_ready high, accepting TAPS pixel/weight pairs
//  DRAIN | two cycles: fold in last product, then register result
//  OUT   | out_valid held until out_ready
module conv_window_mac
  import cnn_fixed_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int FRAC_W = CNN_FRAC_W,
  parameter int TAPS   = 25,
  parameter int ACC_W  = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_window_mac_if.slave bus
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_OUT   = ST_OUT;

  if (TAPS < 1) begin : g_bad_taps
    $error("conv_window_mac: TAPS must be at least 1");
  end
  if (ACC_W < 2*DATA_W + $clog2(TAPS) + 1) begin : g_bad_acc_w
    $error("conv_window_mac: ACC_W too narrow for TAPS products");
  end

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_drain;
  logic                    r_pend;
  logic [2*DATA_W-1:0]     r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic [DATA_W-1:0]       r_out_data;
  logic                    r_sat;

  logic                    w_accept;
  logic [2*DATA_W-1:0]     w_pix_ext;
  logic [2*DATA_W-1:0]     w_wgt_ext;
  logic [2*DATA_W-1:0]     w_prod;
  logic [ACC_W-1:0]        w_prod_ext;
  logic [ACC_W-1:0]        w_bias_ext;
  logic [DATA_W-1:0]       w_sat_data;
  logic                    w_sat;

  assign w_accept = bus.in_valid & (r_state == S_ACCUM);

  // Operands are sign-extended to the full product width, so the low half of the
  // unsigned product is the exact signed result.
  assign w_pix_ext = {{DATA_W{bus.pixel[DATA_W-1]}}, bus.pixel};
  assign w_wgt_ext = {{DATA_W{bus.weight[DATA_W-1]}}, bus.weight};
  assign w_prod    = w_pix_ext * w_wgt_ext;

  assign w_prod_ext = {{(ACC_W-2*DATA_W){r_prod[2*DATA_W-1]}}, r_prod};
  assign w_bias_ext = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias} << FRAC_W;

  q_acc_saturate #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_sat (
    .i_acc  (r_acc),
    .o_data (w_sat_data),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_drain     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              r_state <= S_DRAIN;
              r_drain <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (!r_drain) begin
            r_drain <= 1'b1;
          end else begin
            r_out_data  <= w_sat_data;
            r_sat       <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Product register feeds the accumulator one cycle later; pend marks a product in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_pend <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_pend <= w_accept;
      if (w_accept) begin
        r_prod <= w_prod;
      end
      if ((r_state == S_IDLE) && bus.start) begin
        r_acc <= w_bias_ext;
      end else if (r_pend) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sat_flag  = r_sat;

endmodule
